// File: rtl/knn_scan_ctrl_pkg.sv
// Shared defaults and FSM encoding for the kNN scan controller and its top-K list.
package knn_scan_ctrl_pkg;
  localparam int DEF_WDATA_W = 16;
  localparam int DEF_N_MAX   = 64;
  localparam int DEF_K       = 4;
  localparam int DEF_LABEL_W = 8;
  localparam int DEF_ADDR_W  = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_CMP   = 2'd2,
    S_DONE  = 2'd3
  } scan_state_t;
endpackage

// File: rtl/knn_scan_ctrl_topk.sv
// Sorted K-entry nearest-neighbour list; one insertion per cycle, ascending distance,
// strict less-than so an earlier entry wins ties.
module knn_topk
  import knn_scan_ctrl_pkg::*;
#(
  parameter int DIST_W  = 2*DEF_WDATA_W,
  parameter int LABEL_W = DEF_LABEL_W,
  parameter int K       = DEF_K
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   ins_en,
  input  logic [DIST_W-1:0]      ins_dist,
  input  logic [LABEL_W-1:0]     ins_label,
  output logic [3:0]             count,
  output logic [K*LABEL_W-1:0]   labels,
  output logic [K*DIST_W-1:0]    dists
);
  logic [DIST_W-1:0]  dist_q   [K];
  logic [LABEL_W-1:0] label_q  [K];
  logic [DIST_W-1:0]  prev_dist  [K];
  logic [LABEL_W-1:0] prev_label [K];
  logic [K-1:0]       lt;
  logic [K-1:0]       lt_prev;
  logic [3:0]         count_q, count_d;

  // lt is monotonic across slots because valid entries are kept sorted
  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_slot
      localparam int PREV = (gi == 0) ? 0 : gi - 1;
      assign lt[gi]         = (4'(gi) >= count_q) || (ins_dist < dist_q[gi]);
      assign lt_prev[gi]    = (gi != 0) && lt[PREV];
      assign prev_dist[gi]  = dist_q[PREV];
      assign prev_label[gi] = label_q[PREV];
      assign labels[gi*LABEL_W +: LABEL_W] = label_q[gi];
      assign dists[gi*DIST_W +: DIST_W]    = dist_q[gi];
    end
  endgenerate

  assign count_d = (count_q < 4'(K)) ? count_q + 4'd1 : count_q;
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
      for (int j = 0; j < K; j++) begin
        dist_q[j]  <= '0;
        label_q[j] <= '0;
      end
    end else if (ins_en && lt[K-1]) begin
      count_q <= count_d;
      for (int j = 0; j < K; j++) begin
        if (lt_prev[j]) begin
          dist_q[j]  <= prev_dist[j];
          label_q[j] <= prev_label[j];
        end else if (lt[j]) begin
          dist_q[j]  <= ins_dist;
          label_q[j] <= ins_label;
        end
      end
    end
  end
endmodule

// File: rtl/knn_scan_ctrl.sv
// kNN scan controller: walks the point memory, feeds the external distance core
// and keeps the K nearest points in a sorted list.
module knn_scan_ctrl
  import knn_scan_ctrl_pkg::*;
#(
  parameter int KNN_WDATA_W = DEF_WDATA_W,
  parameter int N_MAX       = DEF_N_MAX,
  parameter int K           = DEF_K,
  parameter int LABEL_W     = DEF_LABEL_W,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_W:0]             n_points,
  input  logic [KNN_WDATA_W-1:0]      test_x,
  input  logic [KNN_WDATA_W-1:0]      test_y,
  output logic                        mem_en,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [KNN_WDATA_W-1:0]      mem_x,
  input  logic [KNN_WDATA_W-1:0]      mem_y,
  input  logic [LABEL_W-1:0]          mem_label,
  output logic [KNN_WDATA_W-1:0]      x1,
  output logic [KNN_WDATA_W-1:0]      y1,
  output logic [KNN_WDATA_W-1:0]      x2,
  output logic [KNN_WDATA_W-1:0]      y2,
  input  logic [2*KNN_WDATA_W-1:0]    d2,
  output logic                        busy,
  output logic                        done,
  output logic [3:0]                  nn_count,
  output logic [K*LABEL_W-1:0]        nn_label,
  output logic [K*2*KNN_WDATA_W-1:0]  nn_dist
);
  localparam logic [ADDR_W:0] NMAX_L = (ADDR_W+1)'(N_MAX);
  localparam logic [ADDR_W:0] ONE_L  = (ADDR_W+1)'(1);

  scan_state_t              state_q;
  logic                     busy_q, done_q, mem_en_q;
  logic [ADDR_W-1:0]        mem_addr_q;
  logic [KNN_WDATA_W-1:0]   tx_q, ty_q;
  logic [ADDR_W:0]          cnt_q, idx_q;
  logic [ADDR_W:0]          idx_d, n_clamp_d;
  logic                     clear, ins_en;

  assign n_clamp_d = (n_points > NMAX_L) ? NMAX_L : n_points;
  assign idx_d     = idx_q + ONE_L;
  assign clear     = (state_q == S_IDLE) && start;
  assign ins_en    = (state_q == S_CMP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      tx_q       <= '0;
      ty_q       <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
    end else begin
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      done_q     <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            tx_q  <= test_x;
            ty_q  <= test_y;
            cnt_q <= n_clamp_d;
            idx_q <= '0;
            if (n_clamp_d == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= S_FETCH;
              mem_en_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
        end
        S_FETCH: state_q <= S_CMP;
        S_CMP: begin
          idx_q <= idx_d;
          if (idx_d < cnt_q) begin
            state_q    <= S_FETCH;
            mem_en_q   <= 1'b1;
            mem_addr_q <= idx_d[ADDR_W-1:0];
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;
  assign x1       = tx_q;
  assign y1       = ty_q;
  // Memory data is only meaningful in CMP; keep the core operands quiet otherwise
  assign x2       = (state_q == S_CMP) ? mem_x : '0;
  assign y2       = (state_q == S_CMP) ? mem_y : '0;

  knn_topk #(
    .DIST_W  (2*KNN_WDATA_W),
    .LABEL_W (LABEL_W),
    .K       (K)
  ) u_topk (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .ins_en    (ins_en),
    .ins_dist  (d2),
    .ins_label (mem_label),
    .count     (nn_count),
    .labels    (nn_label),
    .dists     (nn_dist)
  );
endmodule
